// File: rtl/branch_predictor_bht.sv
// Per-PC branch history table of saturating counters with one branch in flight between IF and ID.
// Optional gshare indexing is enabled by defining GSHARE_EN.
module branch_predictor_bht #(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 16,
  parameter int CTR_BITS    = 2,
  parameter int GHR_BITS    = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            if_branch,
  input  logic [XLEN-1:0] if_pc,
  input  logic [XLEN-1:0] if_target,
  input  logic            id_branch,
  input  logic            id_taken,
  output logic            predict_taken,
  output logic [XLEN-1:0] next_pc,
  output logic            mispredict,
  output logic [31:0]     br_count,
  output logic [31:0]     mp_count
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);

  typedef struct packed {
    logic             valid;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  target;
    logic             pred;
    logic [IDX_W-1:0] idx;
  } inflight_t;

  logic [CTR_BITS-1:0] ctr_q [BHT_ENTRIES];
  logic [CTR_BITS-1:0] ctr_d;
  inflight_t           infl_q, infl_d;
  logic [31:0]         br_count_q, br_count_d;
  logic [31:0]         mp_count_q, mp_count_d;
  logic [IDX_W-1:0]    if_idx;
  logic                active;
  logic                ctr_msb;

`ifdef GSHARE_EN
  logic [GHR_BITS-1:0] ghr_q, ghr_d;

  assign if_idx = if_pc[IDX_W+1:2] ^ IDX_W'(ghr_q);
  // Truncating the concatenation gives the plain shift, and also covers GHR_BITS == 1.
  assign ghr_d  = GHR_BITS'({ghr_q, id_taken});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ghr_q <= '0;
    end else if (active) begin
      ghr_q <= ghr_d;
    end
  end
`else
  assign if_idx = if_pc[IDX_W+1:2];
`endif

  assign active     = rst_n & ~stall & id_branch & infl_q.valid;
  assign mispredict = active & (id_taken != infl_q.pred);
  assign ctr_msb    = ctr_q[if_idx][CTR_BITS-1];
  // A redirecting mispredict squashes whatever IF holds, so its prediction is masked.
  assign predict_taken = rst_n & ~stall & if_branch & ~mispredict & ctr_msb;

  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    next_pc    = if_pc + XLEN'(4);
    ctr_d      = ctr_q[infl_q.idx];
    infl_d     = '0;
    br_count_d = br_count_q;
    mp_count_d = mp_count_q;

    if (mispredict) begin
      next_pc = id_taken ? infl_q.target : infl_q.pc + XLEN'(4);
    end else if (predict_taken) begin
      next_pc = if_target;
    end

    if (id_taken && ctr_d != CTR_MAX) begin
      ctr_d = ctr_d + CTR_BITS'(1);
    end else if (!id_taken && ctr_d != '0) begin
      ctr_d = ctr_d - CTR_BITS'(1);
    end

    if (br_count_q != '1) br_count_d = br_count_q + 32'd1;
    if (mp_count_q != '1) mp_count_d = mp_count_q + 32'd1;

    if (if_branch && !mispredict) begin
      infl_d = '{valid: 1'b1, pc: if_pc, target: if_target, pred: ctr_msb, idx: if_idx};
    end
  end

  // NOTE: non-blocking assignments only in clocked blocks, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the table is reset entry by entry because prediction depends on a known initial bias.
      for (int i = 0; i < BHT_ENTRIES; i++) ctr_q[i] <= CTR_INIT;
      infl_q     <= '0;
      br_count_q <= '0;
      mp_count_q <= '0;
    end else if (!stall) begin
      infl_q <= infl_d;
      if (active) begin
        ctr_q[infl_q.idx] <= ctr_d;
        br_count_q        <= br_count_d;
        if (mispredict) mp_count_q <= mp_count_d;
      end
    end
  end

  assign br_count = br_count_q;
  assign mp_count = mp_count_q;

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Randomized bench for branch_predictor_bht against a behavioural model of the counter table.
module tb_branch_predictor_bht;

  localparam int XLEN    = 32;
  localparam int ENTRIES = 16;
  localparam int CBITS   = 2;
  localparam int GBITS   = 4;
  localparam int CMAX    = (1 << CBITS) - 1;
  localparam int CHALF   = 1 << (CBITS - 1);

  logic            clk = 1'b0;
  logic            rst_n, stall, if_branch, id_branch, id_taken;
  logic [XLEN-1:0] if_pc, if_target;
  logic            predict_taken, mispredict;
  logic [XLEN-1:0] next_pc;
  logic [31:0]     br_count, mp_count;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  int          m_ctr [ENTRIES];
  bit          m_valid;
  bit [31:0]   m_pc, m_tgt;
  bit          m_pred;
  int          m_idx;
  int unsigned m_br, m_mp;
  int          m_ghr;

  branch_predictor_bht #(
    .XLEN(XLEN), .BHT_ENTRIES(ENTRIES), .CTR_BITS(CBITS), .GHR_BITS(GBITS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .if_branch(if_branch), .if_pc(if_pc), .if_target(if_target),
    .id_branch(id_branch), .id_taken(id_taken),
    .predict_taken(predict_taken), .next_pc(next_pc), .mispredict(mispredict),
    .br_count(br_count), .mp_count(mp_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) m_ctr[i] = CHALF - 1;
    m_valid = 0;
    m_br = 0;
    m_mp = 0;
    m_ghr = 0;
  endtask

  // One clock cycle: drive inputs just after an edge, check comb outputs mid-cycle, advance model.
  task automatic step(input bit r, input bit s, input bit ib, input bit [31:0] pc,
                      input bit [31:0] tgt, input bit idb, input bit idt);
    bit        act, exp_mp, exp_pt;
    bit [31:0] exp_npc;
    int        idx;
    rst_n = r; stall = s; if_branch = ib; if_pc = pc; if_target = tgt;
    id_branch = idb; id_taken = idt;

    idx = (pc >> 2) % ENTRIES;
`ifdef GSHARE_EN
    idx = idx ^ m_ghr;
`endif
    act     = r && !s && idb && m_valid;
    exp_mp  = act && (idt != m_pred);
    exp_pt  = r && !s && ib && !exp_mp && (m_ctr[idx] >= CHALF);
    exp_npc = exp_mp ? (idt ? m_tgt : m_pc + 32'd4) : (exp_pt ? tgt : pc + 32'd4);

    #3;
    check("predict_taken", {31'b0, predict_taken}, {31'b0, exp_pt});
    check("mispredict",    {31'b0, mispredict},    {31'b0, exp_mp});
    check("next_pc",       next_pc,  exp_npc);
    check("br_count",      br_count, m_br);
    check("mp_count",      mp_count, m_mp);

    @(posedge clk);
    #1;
    if (!r) begin
      model_reset();
    end else if (!s) begin
      if (act) begin
        if (idt) m_ctr[m_idx] = (m_ctr[m_idx] < CMAX) ? m_ctr[m_idx] + 1 : CMAX;
        else     m_ctr[m_idx] = (m_ctr[m_idx] > 0) ? m_ctr[m_idx] - 1 : 0;
        if (m_br != 32'hFFFF_FFFF) m_br++;
        if (exp_mp && m_mp != 32'hFFFF_FFFF) m_mp++;
        m_ghr = ((m_ghr << 1) | int'(idt)) % (1 << GBITS);
      end
      m_valid = ib && !exp_mp;
      if (m_valid) begin
        m_pc = pc; m_tgt = tgt; m_pred = exp_pt; m_idx = idx;
      end
    end
  endtask

  initial begin
    bit        r, s, ib, idb, idt;
    bit [31:0] pc, tgt;

    rst_n = 0; stall = 0; if_branch = 0; id_branch = 0; id_taken = 0;
    if_pc = 0; if_target = 0;
    #1;
    @(posedge clk);
    #1;
    model_reset();

    // Reset held, with IF activity visible: outputs must follow the reset state.
    step(0, 0, 1, 32'h40, 32'h80, 1, 1);

    // Same branch resolved taken repeatedly, training toward strongly taken.
    for (int k = 0; k < 4; k++) begin
      step(1, 0, 1, 32'h40, 32'h80, 0, 0);
      step(1, 0, 0, 32'h44, 32'h0,  1, 1);
    end
    // Two not-taken resolutions walk the counter back down.
    for (int k = 0; k < 2; k++) begin
      step(1, 0, 1, 32'h40, 32'h80, 0, 0);
      step(1, 0, 0, 32'h80, 32'h0,  1, 0);
    end
    // Aliasing PC, a stalled resolve, and a mispredict with a concurrent IF branch.
    step(1, 0, 1, 32'h80, 32'h100, 0, 0);
    step(1, 1, 1, 32'h84, 32'h200, 1, 1);
    step(1, 0, 1, 32'h84, 32'h200, 1, 1);
    step(1, 0, 0, 32'h88, 32'h0,   1, 1);
    // Wrap of if_pc + 4 and reset while a branch is in flight.
    step(1, 0, 1, 32'hFFFF_FFFF, 32'h10, 0, 0);
    step(1, 0, 1, 32'hFFFF_FFFC, 32'h20, 0, 0);
    step(0, 0, 0, 32'h0, 32'h0, 1, 1);
    step(1, 0, 0, 32'h4, 32'h0, 1, 1);

    for (int n = 0; n < 3000; n++) begin
      r   = ($urandom_range(0, 99) >= 2);
      s   = ($urandom_range(0, 99) < 12);
      ib  = ($urandom_range(0, 99) < 70);
      case ($urandom_range(0, 19))
        0:       pc = 32'hFFFF_FFFC;
        1:       pc = $urandom;
        default: pc = {$urandom_range(0, 47), 2'b00};
      endcase
      tgt = $urandom;
      idb = m_valid ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 4) == 0);
      idt = ($urandom_range(0, 99) < 60);
      step(r, s, ib, pc, tgt, idb, idt);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
